rr_grant_selector: RTL and testbench
====================================

RR_GRANT_SELECTOR -- requirements
Module: rr_grant_selector

Interface
REQ-001 Parameter ITEM_NUM, default 8: number of request slots; SHALL be a power of 2 and at least 2.
REQ-002 Parameter GRANT_NUM, default 2: maximum grants per cycle; SHALL satisfy 1 <= GRANT_NUM <= ITEM_NUM.
REQ-003 Derived width IDW = max(clog2(ITEM_NUM), 1); CNTW = clog2(ITEM_NUM) + 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  discard all pending requests and the output stage.
REQ-007 req_valid  input  1  qualifies req_mask this cycle.
REQ-008 req_mask  input  ITEM_NUM  one bit per slot to mark pending.
REQ-009 out_ready  input  1  consumer accepts the current output stage.
REQ-010 out_valid  output  GRANT_NUM  per-lane grant valid, registered.
REQ-011 out_id  output  IDW x GRANT_NUM (array [0:GRANT_NUM-1])  granted slot index per lane, registered.
REQ-012 pending_count  output  CNTW  popcount of the pending register, registered-derived.
REQ-013 start_pos  output  IDW  current round-robin start pointer.

Function
REQ-014 Internal state: pending[ITEM_NUM-1:0], start pointer, output stage (out_valid, out_id).
REQ-015 Selection: in pending order rotated so that start_pos is checked first, ascending with wrap; the first min(popcount(pending), GRANT_NUM) set slots are candidates, lane k carries the k-th one.
REQ-016 Lanes SHALL fill contiguously from lane 0; out_valid SHALL always be of the form 0..01..1.
REQ-017 load = (out_valid == 0) || out_ready; the output stage SHALL update only when load is 1.
REQ-018 On load: out_valid/out_id take the candidates, and candidate bits form sel_mask; when load is 0, sel_mask = 0 and the outputs hold their values.
REQ-019 pending_next = (pending & ~sel_mask) | (req_valid ? req_mask : 0); a new request SHALL win over a simultaneous clear of the same bit.
REQ-020 If load is 1 and at least one candidate exists, start_next = (last candidate id + 1) mod ITEM_NUM; otherwise start is unchanged.
REQ-021 Latency: a request in cycle t becomes pending in t+1 and appears on out_* in t+2 at the earliest.
REQ-022 A granted slot SHALL NOT be granted again unless re-requested after the cycle in which it was selected.
REQ-023 If out_ready is 0 and out_valid != 0, out_valid/out_id SHALL remain stable and requests SHALL keep accumulating.
REQ-024 flush: next cycle pending = 0 and out_valid = 0; start_pos is kept; req_mask in the flush cycle is dropped; flush overrides load.
REQ-025 pending_count SHALL equal popcount(pending) in the same cycle, with a range of 0..ITEM_NUM.

Reset
REQ-026 rst SHALL override flush and all other inputs.
REQ-027 After rst: pending = 0, out_valid = 0, out_id = 0 on all lanes, start_pos = 0, pending_count = 0.
REQ-028 rst asserted mid-stall SHALL drop held grants; out_valid = 0 in the cycle after reset.

Verification (ITEM_NUM=8, GRANT_NUM=2)
REQ-029 Reset: drive rst for 1 cycle with req_valid=1, req_mask=8'hFF -> out_valid=2'b00, pending_count=0, start_pos=0.
REQ-030 Basic: at start_pos=0, req_mask=8'b1010_0110 at t, out_ready=1 -> t+2: ids {1,2}, valid 2'b11; t+3: ids {5,7}; t+4: valid 2'b00; start_pos=0.
REQ-031 Wrap: req 8'b0110_0000 then, once granted, start_pos=7; then req 8'b1000_1001 -> grants {7,0}, then {3}, out_valid=2'b01, start_pos=4.
REQ-032 Stall: out_ready=0 with ids {1,2} valid; new req 8'h10 arrives -> outputs frozen and pending_count increments; on out_ready=1, the next grant is {4} with the remaining bits.
REQ-033 Set/clear race: slot 3 selected in the same cycle req_mask bit 3 is set -> bit 3 remains pending and is granted again later.
REQ-034 Flush: flush with pending=8'hF0 and valid outputs -> next cycle out_valid=0, pending_count=0, start_pos unchanged.

Source files
------------

// File: rtl/rr_grant_selector.sv
// Round-robin multi-grant selector: accumulates per-slot requests and issues up to
// GRANT_NUM grants per cycle through a registered, back-pressured output stage.
module rr_grant_selector #(
    parameter int ITEM_NUM  = 8,
    parameter int GRANT_NUM = 2,
    localparam int IDW      = ($clog2(ITEM_NUM) > 0) ? $clog2(ITEM_NUM) : 1,
    localparam int CNTW     = $clog2(ITEM_NUM) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 req_valid,
    input  logic [ITEM_NUM-1:0]  req_mask,
    input  logic                 out_ready,
    output logic [GRANT_NUM-1:0] out_valid,
    output logic [IDW-1:0]       out_id [0:GRANT_NUM-1],
    output logic [CNTW-1:0]      pending_count,
    output logic [IDW-1:0]       start_pos
);

    localparam int unsigned NI = ITEM_NUM;
    localparam int unsigned NG = GRANT_NUM;

    logic [ITEM_NUM-1:0]  pending;
    logic [ITEM_NUM-1:0]  cand_mask;
    logic [ITEM_NUM-1:0]  sel_mask;
    logic [GRANT_NUM-1:0] cand_valid;
    logic [IDW-1:0]       cand_id [0:GRANT_NUM-1];
    logic [IDW-1:0]       last_id;
    logic [IDW-1:0]       idx;
    int unsigned          cand_cnt;
    logic                 load;

    // Scan slots starting at start_pos; ITEM_NUM is a power of two so the
    // IDW-bit add wraps exactly at ITEM_NUM.
    always_comb begin
        cand_valid = '0;
        cand_mask  = '0;
        last_id    = start_pos;
        cand_cnt   = 0;
        idx        = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            cand_id[g] = '0;
        end
        for (int unsigned i = 0; i < NI; i++) begin
            idx = start_pos + IDW'(i);
            if (pending[idx] && (cand_cnt < NG)) begin
                for (int unsigned g = 0; g < NG; g++) begin
                    if (g == cand_cnt) begin
                        cand_valid[g] = 1'b1;
                        cand_id[g]    = idx;
                    end
                end
                cand_mask[idx] = 1'b1;
                last_id        = idx;
                cand_cnt       = cand_cnt + 1;
            end
        end
    end

    always_comb begin
        load     = (out_valid == '0) || out_ready;
        sel_mask = load ? cand_mask : '0;
    end

    assign pending_count = CNTW'($countones(pending));

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            start_pos <= '0;
            out_valid <= '0;
            for (int unsigned g = 0; g < NG; g++) begin
                out_id[g] <= '0;
            end
        end else if (flush) begin
            pending   <= '0;
            out_valid <= '0;
        end else begin
            // A same-cycle request re-sets a bit being cleared by selection.
            pending <= (pending & ~sel_mask) | (req_valid ? req_mask : '0);
            if (load) begin
                out_valid <= cand_valid;
                for (int unsigned g = 0; g < NG; g++) begin
                    out_id[g] <= cand_id[g];
                end
                if (cand_valid[0]) begin
                    start_pos <= last_id + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_grant_selector.sv
// Self-checking bench for rr_grant_selector (ITEM_NUM=8, GRANT_NUM=2): directed
// scenarios plus random traffic against a slot-list reference model.
module tb_rr_grant_selector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_mask = '0;
    logic       out_ready = 1'b0;
    logic [1:0] out_valid;
    logic [2:0] out_id [0:1];
    logic [3:0] pending_count;
    logic [2:0] start_pos;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: pending slots as a bit array, grants as lane count + ids.
    bit m_pend [8];
    int m_start = 0;
    int m_nv = 0;
    int m_id [2];

    rr_grant_selector #(.ITEM_NUM(8), .GRANT_NUM(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid),
        .req_mask(req_mask), .out_ready(out_ready), .out_valid(out_valid),
        .out_id(out_id), .pending_count(pending_count), .start_pos(start_pos)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += m_pend[i] ? 1 : 0;
        return c;
    endfunction

    function automatic int m_vmask();
        return (1 << m_nv) - 1;
    endfunction

    // Apply inputs for one cycle, advance the model at the edge, settle 1ns after it.
    task automatic step(input bit r, input bit f, input bit rv, input bit [7:0] m, input bit rdy);
        int cands [$];
        rst = r; flush = f; req_valid = rv; req_mask = m; out_ready = rdy;
        @(posedge clk);
        if (r) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_start = 0; m_nv = 0; m_id[0] = 0; m_id[1] = 0;
        end else if (f) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_nv = 0;
        end else begin
            if (m_nv == 0 || rdy) begin
                for (int i = 0; i < 8; i++) begin
                    int s = (m_start + i) % 8;
                    if (m_pend[s] && cands.size() < 2) cands.push_back(s);
                end
                m_nv = cands.size();
                foreach (cands[k]) begin
                    m_id[k] = cands[k];
                    m_pend[cands[k]] = 0;
                end
                if (cands.size() > 0) m_start = (cands[cands.size()-1] + 1) % 8;
            end
            if (rv) for (int i = 0; i < 8; i++) if (m[i]) m_pend[i] = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 1, 8'hFF, 0);
        vectors++;
        if (out_valid !== 2'b00) begin
            miscompares++; $display("FAIL reset_valid: got %b want 00", out_valid);
        end
        vectors++;
        if (pending_count !== 4'd0) begin
            miscompares++; $display("FAIL reset_count: got %0d want 0", pending_count);
        end
        vectors++;
        if (start_pos !== 3'd0) begin
            miscompares++; $display("FAIL reset_start: got %0d want 0", start_pos);
        end
        vectors++;
        if (out_id[0] !== 3'd0 || out_id[1] !== 3'd0) begin
            miscompares++; $display("FAIL reset_id: got %0d,%0d want 0,0", out_id[0], out_id[1]);
        end
    endtask

    task automatic test_basic();
        step(0, 0, 1, 8'b1010_0110, 1);
        vectors++;
        if (out_valid !== 2'b00 || pending_count !== 4'd4) begin
            miscompares++; $display("FAIL basic_t1: got v=%b cnt=%0d want v=00 cnt=4", out_valid, pending_count);
        end
        step(0, 0, 0, 8'h00, 1);
        vectors++;
        if (out_valid !== 2'b11 || out_id[0] !== 3'd1 || out_id[1] !== 3'd2) begin
            miscompares++; $display("FAIL basic_t2: got v=%b ids=%0d,%0d want v=11 ids=1,2", out_valid, out_id[0], out_id[1]);
        end
        step(0, 0, 0, 8'h00, 1);
        vectors++;
        if (out_valid !== 2'b11 || out_id[0] !== 3'd5 || out_id[1] !== 3'd7) begin
            miscompares++; $display("FAIL basic_t3: got v=%b ids=%0d,%0d want v=11 ids=5,7", out_valid, out_id[0], out_id[1]);
        end
        step(0, 0, 0, 8'h00, 1);
        vectors++;
        if (out_valid !== 2'b00 || start_pos !== 3'd0) begin
            miscompares++; $display("FAIL basic_t4: got v=%b start=%0d want v=00 start=0", out_valid, start_pos);
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 8'b0110_0000, 1);
        step(0, 0, 0, 8'h00, 1);
        vectors++;
        if (out_id[0] !== 3'd5 || out_id[1] !== 3'd6 || start_pos !== 3'd7) begin
            miscompares++; $display("FAIL wrap_first: got ids=%0d,%0d start=%0d want 5,6 start=7", out_id[0], out_id[1], start_pos);
        end
        step(0, 0, 1, 8'b1000_1001, 1);
        step(0, 0, 0, 8'h00, 1);
        vectors++;
        if (out_valid !== 2'b11 || out_id[0] !== 3'd7 || out_id[1] !== 3'd0) begin
            miscompares++; $display("FAIL wrap_grant: got v=%b ids=%0d,%0d want v=11 ids=7,0", out_valid, out_id[0], out_id[1]);
        end
        step(0, 0, 0, 8'h00, 1);
        vectors++;
        if (out_valid !== 2'b01 || out_id[0] !== 3'd3 || start_pos !== 3'd4) begin
            miscompares++; $display("FAIL wrap_tail: got v=%b id=%0d start=%0d want v=01 id=3 start=4", out_valid, out_id[0], start_pos);
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'b1010_0110, 1);
        step(0, 0, 0, 8'h00, 0);
        vectors++;
        if (out_valid !== 2'b11 || out_id[0] !== 3'd1 || out_id[1] !== 3'd2 || pending_count !== 4'd2) begin
            miscompares++; $display("FAIL stall_setup: got v=%b ids=%0d,%0d cnt=%0d want 11 1,2 cnt=2", out_valid, out_id[0], out_id[1], pending_count);
        end
        step(0, 0, 1, 8'h10, 0);
        vectors++;
        if (out_valid !== 2'b11 || out_id[0] !== 3'd1 || out_id[1] !== 3'd2 || pending_count !== 4'd3) begin
            miscompares++; $display("FAIL stall_hold: got v=%b ids=%0d,%0d cnt=%0d want 11 1,2 cnt=3", out_valid, out_id[0], out_id[1], pending_count);
        end
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1);
        vectors++;
        if (out_id[0] !== 3'd4 || out_id[1] !== 3'd5 || start_pos !== 3'd6 || pending_count !== 4'd1) begin
            miscompares++; $display("FAIL stall_release: got ids=%0d,%0d start=%0d cnt=%0d want 4,5 start=6 cnt=1", out_id[0], out_id[1], start_pos, pending_count);
        end
        step(0, 0, 1, 8'h01, 0);
        step(1, 0, 0, 8'h00, 0);
        vectors++;
        if (out_valid !== 2'b00 || pending_count !== 4'd0) begin
            miscompares++; $display("FAIL stall_reset: got v=%b cnt=%0d want 00 cnt=0", out_valid, pending_count);
        end
    endtask

    task automatic test_race();
        step(0, 0, 1, 8'h08, 1);
        step(0, 0, 1, 8'h08, 1);
        vectors++;
        if (out_valid !== 2'b01 || out_id[0] !== 3'd3 || pending_count !== 4'd1) begin
            miscompares++; $display("FAIL race_set: got v=%b id=%0d cnt=%0d want 01 id=3 cnt=1", out_valid, out_id[0], pending_count);
        end
        step(0, 0, 0, 8'h00, 1);
        vectors++;
        if (out_valid !== 2'b01 || out_id[0] !== 3'd3 || pending_count !== 4'd0) begin
            miscompares++; $display("FAIL race_regrant: got v=%b id=%0d cnt=%0d want 01 id=3 cnt=0", out_valid, out_id[0], pending_count);
        end
    endtask

    task automatic test_flush();
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'h03, 1);
        step(0, 0, 1, 8'hF0, 1);
        vectors++;
        if (out_valid !== 2'b11 || pending_count !== 4'd4 || start_pos !== 3'd2) begin
            miscompares++; $display("FAIL flush_setup: got v=%b cnt=%0d start=%0d want 11 cnt=4 start=2", out_valid, pending_count, start_pos);
        end
        step(0, 1, 1, 8'hFF, 1);
        vectors++;
        if (out_valid !== 2'b00 || pending_count !== 4'd0 || start_pos !== 3'd2) begin
            miscompares++; $display("FAIL flush: got v=%b cnt=%0d start=%0d want 00 cnt=0 start=2", out_valid, pending_count, start_pos);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                 $urandom_range(0, 1), 8'($urandom), ($urandom_range(0, 2) != 0));
            vectors++;
            if (out_valid !== 2'(m_vmask()) || pending_count !== 4'(m_count()) || start_pos !== 3'(m_start)) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: got v=%b cnt=%0d start=%0d want v=%b cnt=%0d start=%0d",
                         n, out_valid, pending_count, start_pos, 2'(m_vmask()), m_count(), m_start);
            end
            for (int k = 0; k < m_nv; k++) begin
                vectors++;
                if (out_id[k] !== 3'(m_id[k])) begin
                    miscompares++; $display("FAIL rand_id[%0d] lane %0d: got %0d want %0d", n, k, out_id[k], m_id[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_race();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
